// File: rtl/net_pkg.sv
// Shared types and defaults for the network input decimator slice.
package net_pkg;

  localparam int W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    PULSE
  } dec_state_t;

  // Phase counter width; a RATIO of 1 still needs a one-bit counter.
  function automatic int ph_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/net_input_decimator_if.sv
// Codec-side inputs and network-side outputs of the decimator, grouped as one bus.
interface net_input_decimator_if #(
  parameter int W = net_pkg::W_DEFAULT
);
  logic                sample_clk;
  logic signed [W-1:0] sample_in0;
  logic signed [W-1:0] sample_in1;
  logic signed [W-1:0] sample_in2;
  logic signed [W-1:0] sample_in3;
  logic [7:0]          jack;
  logic signed [W-1:0] net_in0;
  logic signed [W-1:0] net_in1;
  logic signed [W-1:0] net_in2;
  logic signed [W-1:0] net_in3;
  logic                net_sample_clk;
  logic [7:0]          overrun_count;

  modport master (
    output sample_clk, sample_in0, sample_in1, sample_in2, sample_in3, jack,
    input  net_in0, net_in1, net_in2, net_in3, net_sample_clk, overrun_count
  );

  modport slave (
    input  sample_clk, sample_in0, sample_in1, sample_in2, sample_in3, jack,
    output net_in0, net_in1, net_in2, net_in3, net_sample_clk, overrun_count
  );
endinterface

// File: rtl/net_input_decimator_boxcar_acc.sv
// One channel of boxcar accumulation; avg is the floor average of the current block.
module boxcar_acc
  import net_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int RATIO = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                add,
  input  logic                clr,
  input  logic signed [W-1:0] sample,
  output logic signed [W-1:0] avg
);
  localparam int SH = $clog2(RATIO);
  localparam int AW = W + SH;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sample_x;

  assign sample_x = AW'(sample);

  // A sample arriving on the clear cycle seeds the next block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= add ? sample_x : '0;
    end else if (add) begin
      acc <= acc + sample_x;
    end
  end

  assign avg = W'(acc >>> SH);

endmodule

// File: rtl/net_input_decimator.sv
// Decimates four codec channels by RATIO and strobes the result to the network.
//
// state | meaning
// IDLE  | waiting for a block of RATIO samples to complete
// EMIT  | load averaged outputs, clear accumulators (net_sample_clk low)
// PULSE | net_sample_clk high, pulse counter running down
module net_input_decimator
  import net_pkg::*;
#(
  parameter int W         = W_DEFAULT,
  parameter int RATIO     = 4,
  parameter int PULSE_LEN = 4
) (
  input logic                  clk,
  input logic                  rst,
  net_input_decimator_if.slave bus
);
  localparam int              PW      = ph_width(RATIO);
  localparam logic [PW-1:0]   PH_LAST = PW'(RATIO - 1);

  dec_state_t          state, state_nxt;
  logic [3:0]          pcnt, pcnt_nxt;
  logic [PW-1:0]       ph, ph_cur, ph_nxt;
  logic                sclk_q, armed, smp_edge, blk_done, overrun;
  logic [7:0]          ovr_cnt;
  logic signed [W-1:0] smp   [4];
  logic signed [W-1:0] avg   [4];
  logic signed [W-1:0] net_q [4];
  logic                jack_unused;

  assign smp[0] = bus.jack[0] ? bus.sample_in0 : '0;
  assign smp[1] = bus.jack[1] ? bus.sample_in1 : '0;
  assign smp[2] = bus.jack[2] ? bus.sample_in2 : '0;
  assign smp[3] = bus.jack[3] ? bus.sample_in3 : '0;
  assign jack_unused = ^bus.jack[7:4];

  // armed keeps a sample_clk that is already high at reset release from counting as an edge.
  assign smp_edge = bus.sample_clk & ~sclk_q & armed;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    boxcar_acc #(.W(W), .RATIO(RATIO)) u_acc (
      .clk    (clk),
      .rst    (rst),
      .add    (smp_edge),
      .clr    (state == EMIT),
      .sample (smp[i]),
      .avg    (avg[i])
    );
  end

  always_comb begin
    ph_cur   = (state == EMIT) ? '0 : ph;
    blk_done = smp_edge && (ph_cur == PH_LAST);
    ph_nxt   = ph_cur;
    if (smp_edge) ph_nxt = (ph_cur == PH_LAST) ? '0 : ph_cur + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    overrun   = 1'b0;
    case (state)
      IDLE: ;
      EMIT: begin
        state_nxt = PULSE;
        pcnt_nxt  = 4'(PULSE_LEN - 1);
      end
      PULSE: begin
        if (pcnt == 4'd0) state_nxt = IDLE;
        else              pcnt_nxt  = pcnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
    // A block completing mid-pulse cuts the pulse short; its last cycle is not an overrun.
    if (blk_done) begin
      state_nxt = EMIT;
      overrun   = (state == PULSE) && (pcnt != 4'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pcnt    <= '0;
      ph      <= '0;
      sclk_q  <= 1'b0;
      armed   <= 1'b0;
      ovr_cnt <= '0;
      for (int i = 0; i < 4; i++) net_q[i] <= '0;
    end else begin
      state  <= state_nxt;
      pcnt   <= pcnt_nxt;
      ph     <= ph_nxt;
      sclk_q <= bus.sample_clk;
      armed  <= armed | ~bus.sample_clk;
      if (overrun && (ovr_cnt != 8'hFF)) ovr_cnt <= ovr_cnt + 8'd1;
      if (state == EMIT) begin
        for (int i = 0; i < 4; i++) net_q[i] <= avg[i];
      end
    end
  end

  assign bus.net_in0        = net_q[0];
  assign bus.net_in1        = net_q[1];
  assign bus.net_in2        = net_q[2];
  assign bus.net_in3        = net_q[3];
  assign bus.net_sample_clk = (state == PULSE);
  assign bus.overrun_count  = ovr_cnt;

endmodule

// File: tb/tb_net_input_decimator.sv
// Bench: a RATIO=4 and a RATIO=1 decimator share stimulus and are checked against a block-level model.
module tb_net_input_decimator;
  import net_pkg::*;

  localparam int W  = 16;
  localparam int PL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                sclk;
  logic signed [W-1:0] s [4];
  logic [7:0]          jk;

  net_input_decimator_if #(.W(W)) b4 ();
  net_input_decimator_if #(.W(W)) b1 ();

  assign b4.sample_clk = sclk;
  assign b4.sample_in0 = s[0];
  assign b4.sample_in1 = s[1];
  assign b4.sample_in2 = s[2];
  assign b4.sample_in3 = s[3];
  assign b4.jack       = jk;
  assign b1.sample_clk = sclk;
  assign b1.sample_in0 = s[0];
  assign b1.sample_in1 = s[1];
  assign b1.sample_in2 = s[2];
  assign b1.sample_in3 = s[3];
  assign b1.jack       = jk;

  net_input_decimator #(.W(W), .RATIO(4), .PULSE_LEN(PL)) u4 (.clk(clk), .rst(rst), .bus(b4));
  net_input_decimator #(.W(W), .RATIO(1), .PULSE_LEN(PL)) u1 (.clk(clk), .rst(rst), .bus(b1));

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  // Block-level model: index 0 is the RATIO=4 instance, index 1 the RATIO=1 instance.
  int m_r [2] = '{4, 1};
  int m_prev [2];
  int m_cnt [2];
  int m_sum [2][4];
  int m_net [2][4];
  int m_pnet [2][4];
  bit m_pend [2];
  int m_last [2];
  int m_ovr [2];

  function automatic int fdiv(input int a, input int r);
    int q;
    q = a / r;
    if ((a % r != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_prev[d] = 1;
      m_cnt[d]  = 0;
      m_pend[d] = 1'b0;
      m_last[d] = -1000;
      m_ovr[d]  = 0;
      for (int c = 0; c < 4; c++) begin
        m_sum[d][c]  = 0;
        m_net[d][c]  = 0;
        m_pnet[d][c] = 0;
      end
    end
  endtask

  task automatic model_cycle();
    bit e;
    for (int d = 0; d < 2; d++) begin
      e = (sclk == 1'b1) && (m_prev[d] == 0);
      m_prev[d] = int'(sclk);
      if (m_pend[d]) begin
        for (int c = 0; c < 4; c++) m_net[d][c] = m_pnet[d][c];
        m_last[d] = cyc;
        m_pend[d] = 1'b0;
      end
      if (e) begin
        for (int c = 0; c < 4; c++) m_sum[d][c] += jk[c] ? int'(s[c]) : 0;
        m_cnt[d]++;
        if (m_cnt[d] == m_r[d]) begin
          for (int c = 0; c < 4; c++) begin
            m_pnet[d][c] = fdiv(m_sum[d][c], m_r[d]);
            m_sum[d][c]  = 0;
          end
          m_cnt[d]  = 0;
          m_pend[d] = 1'b1;
          if ((cyc + 1 > m_last[d]) && (cyc + 1 <= m_last[d] + PL) && (m_ovr[d] < 255))
            m_ovr[d]++;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic chk_dut(input int d, input logic signed [W-1:0] n0, input logic signed [W-1:0] n1,
                         input logic signed [W-1:0] n2, input logic signed [W-1:0] n3,
                         input logic nsc, input logic [7:0] ov);
    int exp_nsc;
    exp_nsc = (!m_pend[d] && (cyc > m_last[d]) && (cyc <= m_last[d] + PL)) ? 1 : 0;
    chk($sformatf("r%0d_net0", m_r[d]), int'(n0), m_net[d][0]);
    chk($sformatf("r%0d_net1", m_r[d]), int'(n1), m_net[d][1]);
    chk($sformatf("r%0d_net2", m_r[d]), int'(n2), m_net[d][2]);
    chk($sformatf("r%0d_net3", m_r[d]), int'(n3), m_net[d][3]);
    chk($sformatf("r%0d_nsc", m_r[d]), int'(nsc), exp_nsc);
    chk($sformatf("r%0d_ovr", m_r[d]), int'(ov), m_ovr[d]);
  endtask

  task automatic check_all();
    chk_dut(0, b4.net_in0, b4.net_in1, b4.net_in2, b4.net_in3, b4.net_sample_clk, b4.overrun_count);
    chk_dut(1, b1.net_in0, b1.net_in1, b1.net_in2, b1.net_in3, b1.net_sample_clk, b1.overrun_count);
  endtask

  // Called at a negedge: drive one cycle of inputs, advance, compare at the next negedge.
  task automatic step(input logic sc, input int v0, input int v1, input int v2, input int v3,
                      input logic [7:0] j);
    sclk = sc;
    s[0] = W'(v0);
    s[1] = W'(v1);
    s[2] = W'(v2);
    s[3] = W'(v3);
    jk   = j;
    @(posedge clk);
    model_cycle();
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic edges(input int n, input int v, input int gap);
    for (int k = 0; k < n; k++) begin
      step(1'b1, v, v, v, v, 8'hFF);
      for (int g = 0; g < gap; g++) step(1'b0, v, v, v, v, 8'hFF);
    end
  endtask

  task automatic do_reset(input logic rel_sc);
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    for (int k = 0; k < 3; k++) begin
      sclk = k[0];
      @(posedge clk);
      #1;
      check_all();
    end
    @(negedge clk);
    sclk = rel_sc;
    rst  = 1'b0;
  endtask

  typedef struct {
    logic sc;
    int   s0;
    int   s1;
    int   e_net0;
    int   e_net1;
    logic e_nsc;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b0,   0,  0,   0,  0, 1'b0};
    tbl[1]  = '{1'b1, 100, -1,   0,  0, 1'b0};
    tbl[2]  = '{1'b0, 100, -1,   0,  0, 1'b0};
    tbl[3]  = '{1'b1, 200, -1,   0,  0, 1'b0};
    tbl[4]  = '{1'b0, 200, -1,   0,  0, 1'b0};
    tbl[5]  = '{1'b1, 300, -1,   0,  0, 1'b0};
    tbl[6]  = '{1'b0, 300, -1,   0,  0, 1'b0};
    tbl[7]  = '{1'b1, 400, -2,   0,  0, 1'b0};
    tbl[8]  = '{1'b0, 400, -2, 250, -2, 1'b1};
    tbl[9]  = '{1'b0,   0,  0, 250, -2, 1'b1};
    tbl[10] = '{1'b0,   0,  0, 250, -2, 1'b1};
    tbl[11] = '{1'b0,   0,  0, 250, -2, 1'b1};
    tbl[12] = '{1'b0,   0,  0, 250, -2, 1'b0};
    tbl[13] = '{1'b0,   0,  0, 250, -2, 1'b0};

    sclk = 1'b0;
    jk   = 8'hFF;
    for (int c = 0; c < 4; c++) s[c] = '0;
    @(negedge clk);
    do_reset(1'b0);

    // Directed table: channel 0 average 250 with pulse timing, channel 1 floor of -5/4.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].sc, tbl[i].s0, tbl[i].s1, 0, 0, 8'hFF);
      chk("tbl_net0", int'(b4.net_in0), tbl[i].e_net0);
      chk("tbl_net1", int'(b4.net_in1), tbl[i].e_net1);
      chk("tbl_nsc", int'(b4.net_sample_clk), int'(tbl[i].e_nsc));
    end

    // Unplugged channel 0 held at full scale must read zero.
    do_reset(1'b0);
    step(1'b0, 0, 0, 0, 0, 8'h0E);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 32'h7FFF, $urandom, $urandom, $urandom, 8'h0E);
      step(1'b0, 32'h7FFF, 0, 0, 0, 8'h0E);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 32'h7FFF, 0, 0, 0, 8'h0E);
    chk("jack_net0", int'(b4.net_in0), 0);

    // RATIO=1 with edges three cycles apart: every emit after the first overruns, then saturates.
    do_reset(1'b0);
    step(1'b0, 0, 0, 0, 0, 8'hFF);
    for (int k = 0; k < 300; k++) begin
      step(1'b1, $urandom, $urandom, $urandom, $urandom, 8'hFF);
      step(1'b0, 0, 0, 0, 0, 8'hFF);
      step(1'b0, 0, 0, 0, 0, 8'hFF);
      if (k == 4) chk("ovr_after5", int'(b1.overrun_count), 4);
    end
    chk("ovr_sat", int'(b1.overrun_count), 255);

    // Reset mid-pulse and mid-block; the following block must not inherit anything.
    do_reset(1'b0);
    step(1'b0, 0, 0, 0, 0, 8'hFF);
    edges(4, 1000, 1);
    step(1'b0, 0, 0, 0, 0, 8'hFF);
    edges(2, 1000, 1);
    do_reset(1'b0);
    step(1'b0, 0, 0, 0, 0, 8'hFF);
    edges(4, 8, 1);
    for (int k = 0; k < 6; k++) step(1'b0, 0, 0, 0, 0, 8'hFF);
    chk("rst_leak0", int'(b4.net_in0), 8);
    chk("rst_leak3", int'(b4.net_in3), 8);

    // Full-scale extremes average without wrap.
    do_reset(1'b0);
    step(1'b0, 0, 0, 0, 0, 8'hFF);
    edges(4, 32'h7FFF, 1);
    for (int k = 0; k < 6; k++) step(1'b0, 0, 0, 0, 0, 8'hFF);
    chk("max_net2", int'(b4.net_in2), 32767);
    edges(4, -32768, 1);
    for (int k = 0; k < 6; k++) step(1'b0, 0, 0, 0, 0, 8'hFF);
    chk("min_net2", int'(b4.net_in2), -32768);

    // sample_clk already high at release is not a sample.
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 500, 500, 500, 500, 8'hFF);
    step(1'b0, 0, 0, 0, 0, 8'hFF);
    edges(4, 4, 1);
    for (int k = 0; k < 6; k++) step(1'b0, 0, 0, 0, 0, 8'hFF);
    chk("release_high", int'(b4.net_in0), 4);

    // Randomized traffic with occasional mid-stream resets.
    do_reset(1'b0);
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] j;
      case ($urandom_range(0, 3))
        0:       j = 8'h0E;
        1:       j = 8'(($urandom));
        default: j = 8'hFF;
      endcase
      step(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom, j);
      if (k % 750 == 749) do_reset(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/net_input_decimator.md
NET_INPUT_DECIMATOR -- requirements
Module: net_input_decimator

Interface
REQ-001 SHALL have parameter W, default 16: sample width in bits.
REQ-002 SHALL have parameter RATIO, default 4: decimation ratio; power of two, range 1..64.
REQ-003 SHALL have parameter PULSE_LEN, default 4: net_sample_clk high time in clk cycles; range 1..15.
REQ-004 SHALL have port clk, input, 1: system clock; the block's only clock.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port sample_clk, input, 1: codec sample strobe, synchronous to clk; its rising edge marks a new sample.
REQ-007 SHALL have ports sample_in0..sample_in3, input, W each, signed: codec samples, valid while sample_clk is high.
REQ-008 SHALL have port jack, input, 8: jack[i]=0 marks input i (i=0..3) unplugged.
REQ-009 SHALL have ports net_in0..net_in3, output, W each, signed: decimated samples for the network.
REQ-010 SHALL have port net_sample_clk, output, 1: decimated strobe to the network's sample_clk input.
REQ-011 SHALL have port overrun_count, output, 8: saturating count of emits that land while net_sample_clk is high.

Function
REQ-012 SHALL register sample_clk each cycle; edge cycle E is a cycle with sample_clk=1 and the registered value=0.
REQ-013 SHALL, at the end of cycle E, add each channel's sample (forced to 0 when its jack bit is 0) to a signed accumulator of width W+log2(RATIO), and increment phase counter ph modulo RATIO.
REQ-014 SHALL, when the addition at E completes RATIO samples (ph was RATIO-1), set state EMIT for cycle E+1.
REQ-015 SHALL, in EMIT, load net_inN = accN >>> log2(RATIO) (arithmetic shift, floor toward minus infinity), clear all accumulators, and set ph=0.
REQ-016 SHALL, in EMIT, also add a sample when E+1 is itself an edge cycle: that sample goes into the cleared accumulator, and ph becomes 1.
REQ-017 SHALL assert net_sample_clk from cycle E+2 for exactly PULSE_LEN cycles; FSM states are IDLE -> EMIT -> PULSE (down-counter) -> IDLE.
REQ-018 SHALL accept sample edges in every state; accumulation never stalls.
REQ-019 SHALL, when EMIT occurs while in PULSE, hold net_sample_clk low for exactly one cycle, restart the full PULSE_LEN pulse, and increment overrun_count, saturating at 255.
REQ-020 SHALL hold net_inN constant between EMITs.
REQ-021 SHALL behave as registered passthrough when RATIO=1: every edge emits, and net_inN = masked sample_inN.
REQ-022 SHALL never saturate the output; the average of W-bit values fits in W bits by construction.

Reset
REQ-023 SHALL, on rst assertion and without waiting for clk, clear the accumulators, ph, net_in0..3, net_sample_clk, overrun_count, and the sample_clk history register, and put the FSM in IDLE.
REQ-024 SHALL discard any partially accumulated block and any in-flight pulse when reset is asserted mid-operation, with no glitch on net_sample_clk.
REQ-025 SHALL, after reset release, treat the first sample_clk rising edge as sample 0 of a new block; a sample_clk already high at release is not an edge.

Structure
REQ-026 SHALL take the FSM state enum (IDLE, EMIT, PULSE) and the default W from the shared package net_pkg.
REQ-027 SHALL instantiate one sub-module, boxcar_acc, four times (one per channel); it holds the accumulator, add and clear logic, parameterised by W and RATIO.
REQ-028 SHALL keep the edge detect, phase counter, FSM, pulse counter and overrun counter in the top level.

Verification
REQ-029 SHALL cover: RATIO=4, ch0 samples 100,200,300,400 on four edges -> net_in0=250 loaded at E4+1, net_sample_clk high at E4+2..E4+5.
REQ-030 SHALL cover: RATIO=4, ch1 samples -1,-1,-1,-2 -> net_in1=-2 (floor of -5/4).
REQ-031 SHALL cover: jack=8'h0E, sample_in0=0x7FFF constant -> net_in0=0 after every emit; channels 1..3 pass their averages.
REQ-032 SHALL cover: RATIO=1, PULSE_LEN=4, sample_clk edges 3 cycles apart -> overrun_count increments on each emit after the first, and net_sample_clk shows a one-cycle low then a full restart.
REQ-033 SHALL cover: rst asserted after 2 of 4 samples, then 4 samples of 8 -> net_in=8 (no leakage from the discarded partial block); net_sample_clk low throughout reset.
REQ-034 SHALL cover: RATIO=4, all samples 0x7FFF, then all 0x8000 -> net_in=0x7FFF, then 0x8000, with no wrap.
